// File: rtl/player_status_ctrl.sv
// player_status_ctrl: top-level player state machine (IDLE/PLAYING/HURT/GAME_OVER)
// driving hit-blink visibility, input freeze, game-over flag and the lives-reset pulse.
`default_nettype none

module player_status_ctrl #(
  parameter int unsigned FLASH_FRAMES     = 60,
  parameter int unsigned BLINK_FRAMES     = 4,
  parameter int unsigned OVER_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       player_hurt,
  input  logic [1:0] player_lives,
  input  logic       start_btn,
  output logic [1:0] state,
  output logic       player_visible,
  output logic       input_freeze,
  output logic       game_over,
  output logic       hurt_active,
  output logic       lives_reset
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PLAYING   = 2'b01,
    S_HURT      = 2'b10,
    S_GAME_OVER = 2'b11
  } state_e;

  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] OVER_HOLD  = 8'(OVER_HOLD_FRAMES);

  state_e     state_q, state_d;
  logic       visible_q, visible_d;
  logic       freeze_q, freeze_d;
  logic       game_over_q, game_over_d;
  logic       hurt_q, hurt_d;
  logic       lives_reset_q, lives_reset_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       rearm_q, rearm_d;
  logic       vsync_q, hist_valid_q, frame_tick_q;

  // hist_valid_q suppresses a tick from a vsync level already high at reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b0;
      hist_valid_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      hist_valid_q <= 1'b1;
      frame_tick_q <= vsync & ~vsync_q & hist_valid_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    visible_d     = visible_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    rearm_d       = rearm_q;
    lives_reset_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        visible_d = 1'b1;
        if (frame_tick_q && start_btn) begin
          state_d       = S_PLAYING;
          lives_reset_d = 1'b1;
        end
      end
      S_PLAYING: begin
        visible_d = 1'b1;
        if (player_lives == 2'd0) begin
          state_d = S_GAME_OVER;
        end else if (player_hurt) begin
          state_d     = S_HURT;
          frame_cnt_d = 8'd0;
          blink_cnt_d = 8'd0;
          visible_d   = 1'b0;
        end
      end
      S_HURT: begin
        if (player_hurt && player_lives == 2'd0) begin
          state_d = S_GAME_OVER;
        end else if (player_hurt) begin
          frame_cnt_d = 8'd0;
          blink_cnt_d = 8'd0;
          visible_d   = 1'b0;
        end else if (frame_tick_q) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (blink_cnt_q == BLINK_LAST) begin
            visible_d   = ~visible_q;
            blink_cnt_d = 8'd0;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
          if (frame_cnt_q == FLASH_LAST) begin
            state_d   = S_PLAYING;
            visible_d = 1'b1;
          end
        end
      end
      default: begin
        if (!start_btn) rearm_d = 1'b1;
        if (frame_tick_q && frame_cnt_q < OVER_HOLD) frame_cnt_d = frame_cnt_q + 8'd1;
        if (frame_tick_q && start_btn && rearm_q && frame_cnt_q >= OVER_HOLD) begin
          state_d       = S_PLAYING;
          visible_d     = 1'b1;
          lives_reset_d = 1'b1;
        end
      end
    endcase

    // Entering GAME_OVER restarts the hold timer and demands a fresh button release
    if (state_d == S_GAME_OVER && state_q != S_GAME_OVER) begin
      frame_cnt_d = 8'd0;
      rearm_d     = 1'b0;
    end
    if (state_d == S_GAME_OVER) visible_d = 1'b0;

    freeze_d    = (state_d == S_IDLE) || (state_d == S_GAME_OVER);
    game_over_d = (state_d == S_GAME_OVER);
    hurt_d      = (state_d == S_HURT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      visible_q     <= 1'b1;
      freeze_q      <= 1'b1;
      game_over_q   <= 1'b0;
      hurt_q        <= 1'b0;
      lives_reset_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      blink_cnt_q   <= 8'd0;
      rearm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      visible_q     <= visible_d;
      freeze_q      <= freeze_d;
      game_over_q   <= game_over_d;
      hurt_q        <= hurt_d;
      lives_reset_q <= lives_reset_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      rearm_q       <= rearm_d;
    end
  end

  assign state          = state_q;
  assign player_visible = visible_q;
  assign input_freeze   = freeze_q;
  assign game_over      = game_over_q;
  assign hurt_active    = hurt_q;
  assign lives_reset    = lives_reset_q;

endmodule

`default_nettype wire

// File: tb/tb_player_status_ctrl.sv
// Directed self-checking bench for player_status_ctrl with default parameters.
`default_nettype none

module tb_player_status_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b0;
  logic       player_hurt = 1'b0;
  logic [1:0] player_lives = 2'd3;
  logic       start_btn = 1'b0;
  logic [1:0] state;
  logic       player_visible, input_freeze, game_over, hurt_active, lives_reset;

  int checks = 0;
  int errors = 0;

  player_status_ctrl #(
    .FLASH_FRAMES(60), .BLINK_FRAMES(4), .OVER_HOLD_FRAMES(120)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .player_hurt(player_hurt),
    .player_lives(player_lives), .start_btn(start_btn), .state(state),
    .player_visible(player_visible), .input_freeze(input_freeze),
    .game_over(game_over), .hurt_active(hurt_active), .lives_reset(lives_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // state, visible, freeze, game_over, hurt_active, lives_reset
  task automatic chk_all(input string tag, input logic [1:0] st, input logic vis,
                         input logic frz, input logic go, input logic ha, input logic lr);
    chk({tag, ".state"},   8'(state), 8'(st));
    chk({tag, ".visible"}, 8'(player_visible), 8'(vis));
    chk({tag, ".freeze"},  8'(input_freeze), 8'(frz));
    chk({tag, ".gameover"},8'(game_over), 8'(go));
    chk({tag, ".hurt"},    8'(hurt_active), 8'(ha));
    chk({tag, ".lreset"},  8'(lives_reset), 8'(lr));
  endtask

  // Called at a negedge; returns at the negedge after the tick has been acted on.
  task automatic tick(input logic st);
    start_btn = st;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic st);
    for (int i = 0; i < n; i++) tick(st);
  endtask

  task automatic hurt(input logic [1:0] l);
    player_hurt  = 1'b1;
    player_lives = l;
    @(negedge clk);
    player_hurt  = 1'b0;
  endtask

  initial begin
    // Reset held with vsync toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vsync = ~vsync;
      start_btn = 1'b1;
    end
    chk_all("in_reset", 2'b00, 1, 1, 0, 0, 0);

    // Release with vsync already high: no tick, stays IDLE
    vsync = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("release_vsync_high", 2'b00, 1, 1, 0, 0, 0);
    vsync = 1'b0;
    start_btn = 1'b0;
    repeat (2) @(negedge clk);

    // Start from IDLE
    tick(1'b1);
    chk_all("start", 2'b01, 1, 0, 0, 0, 1);
    start_btn = 1'b0;
    @(negedge clk);
    chk("start_pulse_width", 8'(lives_reset), 8'd0);

    // Hit with lives=2, blink every 4 ticks, exit after 60 ticks
    hurt(2'd2);
    chk_all("hurt_entry", 2'b10, 0, 0, 0, 1, 0);
    ticks(3, 1'b0);
    chk("blink_t3", 8'(player_visible), 8'd0);
    tick(1'b0);
    chk("blink_t4", 8'(player_visible), 8'd1);
    ticks(4, 1'b0);
    chk("blink_t8", 8'(player_visible), 8'd0);
    ticks(51, 1'b0);
    chk_all("hurt_t59", 2'b10, 0, 0, 0, 1, 0);
    tick(1'b0);
    chk_all("hurt_exit_t60", 2'b01, 1, 0, 0, 0, 0);

    // Re-hit at tick 30 restarts the window
    hurt(2'd2);
    ticks(30, 1'b0);
    chk("rehit_pre_vis", 8'(player_visible), 8'd1);
    hurt(2'd1);
    chk_all("rehit", 2'b10, 0, 0, 0, 1, 0);
    ticks(59, 1'b0);
    chk("rehit_t59", 8'(state), 8'd2);
    tick(1'b0);
    chk_all("rehit_exit", 2'b01, 1, 0, 0, 0, 0);

    // Fatal hit in PLAYING with start held throughout GAME_OVER
    start_btn = 1'b1;
    hurt(2'd0);
    chk_all("go_from_play", 2'b11, 0, 1, 1, 0, 0);
    ticks(125, 1'b1);
    chk_all("go_start_held", 2'b11, 0, 1, 1, 0, 0);
    player_lives = 2'd3;
    tick(1'b0);
    chk("go_released", 8'(state), 8'd3);
    tick(1'b1);
    chk_all("go_restart", 2'b01, 1, 0, 0, 0, 1);
    start_btn = 1'b0;
    @(negedge clk);
    chk("go_restart_pulse_width", 8'(lives_reset), 8'd0);

    // Fatal hit while in HURT; hold-time boundary
    hurt(2'd2);
    hurt(2'd0);
    chk_all("go_from_hurt", 2'b11, 0, 1, 1, 0, 0);
    ticks(49, 1'b0);
    tick(1'b1);
    chk("go_press_t50", 8'(state), 8'd3);
    ticks(69, 1'b0);
    tick(1'b1);
    chk("go_press_t120", 8'(state), 8'd3);
    player_lives = 2'd3;
    tick(1'b1);
    chk_all("go_press_t121", 2'b01, 1, 0, 0, 0, 1);
    start_btn = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-HURT
    hurt(2'd2);
    ticks(5, 1'b0);
    chk("pre_reset_hurt", 8'(state), 8'd2);
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 2'b00, 1, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 2'b00, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_lr", 8'(lives_reset), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/player_status_ctrl.md
# player_status_ctrl

Per-frame game-status controller downstream of the hearts/lives counter. Consumes its one-cycle hurt pulse and 2-bit lives count, and runs the top-level player state machine (IDLE, PLAYING, HURT, GAME_OVER). Drives the post-hit invulnerability blink, the input freeze and the game-over flag. Issues the one-cycle lives-reset pulse that restores the hearts counter when a game starts.

## Interface
Parameters:
- FLASH_FRAMES, 60: frames spent in HURT after a hit (1..255)
- BLINK_FRAMES, 4: frames per visibility toggle while in HURT (1..255)
- OVER_HOLD_FRAMES, 120: minimum frames in GAME_OVER before restart is accepted (1..255)

Ports:
- clk  in  1  system clock, the single clock domain
- reset  in  1  asynchronous, active-low reset
- vsync  in  1  frame sync level, synchronous to clk
- player_hurt  in  1  one-cycle pulse from the hearts counter; player_lives already holds the decremented value in that cycle
- player_lives  in  2  remaining lives, 0..3
- start_btn  in  1  start/restart button level, synchronous and debounced
- state  out  2  IDLE=00, PLAYING=01, HURT=10, GAME_OVER=11
- player_visible  out  1  sprite enable for the player renderer
- input_freeze  out  1  high = ignore movement/attack inputs
- game_over  out  1  high while in GAME_OVER
- hurt_active  out  1  high while in HURT (invulnerability window)
- lives_reset  out  1  one-cycle pulse to the hearts counter's active-high reset

## Operation
- Frame tick: an internal registered vsync history bit feeds a one-cycle frame_tick. frame_tick is high in the cycle after clk first samples vsync=1 with the previous sample 0.
- Internal 8-bit frame_cnt, 8-bit blink_cnt and a rearm flag.
- IDLE: visible=1, freeze=1.
  - frame_tick with start_btn=1 moves to PLAYING and pulses lives_reset.
- PLAYING: visible=1, freeze=0.
  - player_hurt=1 with player_lives=0 moves to GAME_OVER.
  - player_hurt=1 with player_lives>0 moves to HURT, clears frame_cnt and blink_cnt, and sets visible=0.
  - player_lives=0 without a pulse also moves to GAME_OVER.
- HURT: hurt_active=1, freeze=0.
  - frame_cnt increments on each frame_tick.
  - blink_cnt increments on each frame_tick. When it reaches BLINK_FRAMES-1 on a tick, player_visible toggles and blink_cnt clears.
  - When frame_cnt reaches FLASH_FRAMES-1 on a tick, the block returns to PLAYING with visible=1.
  - A new player_hurt with lives>0 restarts the counters (visible=0). A new player_hurt with lives=0 moves to GAME_OVER; this takes priority over the flash-expiry exit.
- GAME_OVER: game_over=1, freeze=1, visible=0.
  - On entry, frame_cnt clears and rearm clears.
  - frame_cnt increments on each tick and saturates at OVER_HOLD_FRAMES.
  - rearm sets in any cycle where start_btn=0.
  - frame_tick with start_btn=1, rearm=1 and frame_cnt≥OVER_HOLD_FRAMES moves to PLAYING and pulses lives_reset.
- player_hurt is ignored in IDLE and GAME_OVER.
- lives_reset is never high for more than one cycle and is high only on PLAYING entry from IDLE or GAME_OVER.

## Timing
- Reset values (asserted asynchronously, held while reset=0):
  - state=IDLE, player_visible=1, input_freeze=1
  - game_over=0, hurt_active=0, lives_reset=0
  - counters=0, rearm=0, vsync history=0
- All outputs are registered. A transition triggered by inputs sampled at edge N is visible after edge N, with lives_reset high for exactly that cycle.
- The hurt response has 1-cycle latency from the player_hurt pulse.
- The HURT duration is exactly FLASH_FRAMES frame_ticks.
- Release of reset is synchronous to the next clk edge. No frame_tick is generated from a vsync already high at release.
- Reset asserted mid-HURT or mid-GAME_OVER returns the block to IDLE immediately and does not pulse lives_reset.

## Test plan
- Reset low, vsync toggling → state=00, visible=1, freeze=1, lives_reset=0. Start held high across 1 tick → state=01 one cycle later, lives_reset high exactly 1 cycle.
- PLAYING, hurt pulse with lives=2 → state=10 next cycle, visible=0. With BLINK_FRAMES=4, visible toggles every 4 ticks. After 60 ticks → state=01, visible=1.
- HURT at tick 30, second hurt pulse with lives=1 → counters restart, and HURT lasts a further 60 ticks from the pulse.
- Hurt pulse with lives=0 in PLAYING and again in HURT → state=11, game_over=1, freeze=1, visible=0.
- GAME_OVER with start held continuously → no restart even past 120 ticks. Release start, then press after tick 120 → state=01 and one lives_reset pulse. Press at tick 50 → ignored.
- Reset asserted mid-HURT → outputs at reset values immediately. No lives_reset pulse.
